// File: rtl/tas_pkg.sv
// Shared types and defaults for the averaged-data RAM scheduler.
package tas_pkg;

  localparam int unsigned TAS_ADDR_W = 11;
  localparam int unsigned TAS_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ram_sched_if.sv
// Host readout request bus: the host is master, the scheduler is slave.
interface ram_sched_if
  import tas_pkg::*;
#(
  parameter int ADDR_W = TAS_ADDR_W,
  parameter int DATA_W = TAS_DATA_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, rd_addr, input rd_busy, rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_busy, rd_ack, rd_data);

endinterface

// File: rtl/wr_capture.sv
// Holds the averager byte until the scheduler consumes it; flags overwrites.
module wr_capture
  import tas_pkg::*;
#(
  parameter int DATA_W = TAS_DATA_W
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_avg_wr_n,
  input  logic [DATA_W-1:0] i_avg_data,
  input  logic              i_consume,
  output logic [DATA_W-1:0] o_wr_hold,
  output logic              o_wr_pend,
  output logic              o_ovf
);

  logic [DATA_W-1:0] r_hold;
  logic              r_pend;
  logic              r_ovf;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      r_hold <= '0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (!i_avg_wr_n) begin
      // A strobe landing on the consume cycle simply refills the slot.
      r_hold <= i_avg_data;
      r_pend <= 1'b1;
      if (r_pend && !i_consume) r_ovf <= 1'b1;
    end else if (i_consume) begin
      r_pend <= 1'b0;
    end
  end

  assign o_wr_hold = r_hold;
  assign o_wr_pend = r_pend;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/ram_sched.sv
// Arbitrates the single-port averaged-data RAM: averager writes first, host reads next.
module ram_sched
  import tas_pkg::*;
#(
  parameter int ADDR_W = TAS_ADDR_W,
  parameter int DATA_W = TAS_DATA_W,
  parameter int WRAP   = 0
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              avg_wr_n,
  input  logic [DATA_W-1:0] avg_data,
  ram_sched_if.slave        rd_if,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_P = 1;

  sched_state_e      r_state;
  logic [ADDR_W-1:0] r_rd_hold;
  logic              r_rd_busy;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_full;
  logic              r_full_ovf;

  logic [DATA_W-1:0] w_hold;
  logic              w_pend;
  logic              w_cap_ovf;
  logic              w_consume;
  logic [ADDR_W:0]   w_ptr_next;

  assign w_consume = (r_state == WRITE);

  wr_capture #(.DATA_W(DATA_W)) u_wr_capture (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .i_clr      (clr),
    .i_avg_wr_n (avg_wr_n),
    .i_avg_data (avg_data),
    .i_consume  (w_consume),
    .o_wr_hold  (w_hold),
    .o_wr_pend  (w_pend),
    .o_ovf      (w_cap_ovf)
  );

  always_comb begin
    if (WRAP != 0) w_ptr_next = {1'b0, r_wr_ptr[ADDR_W-1:0] + ONE_A};
    else           w_ptr_next = r_wr_ptr + ONE_P;
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rd_hold  <= '0;
      r_rd_busy  <= 1'b0;
      r_rd_data  <= '0;
      r_wr_ptr   <= '0;
      r_full     <= 1'b0;
      r_full_ovf <= 1'b0;
    end else begin
      if (rd_if.rd_req && !r_rd_busy) begin
        r_rd_hold <= rd_if.rd_addr;
        r_rd_busy <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_pend)         r_state <= WRITE;
          else if (r_rd_busy) r_state <= RD_ISSUE;
        end
        WRITE: begin
          if (WRAP == 0 && r_full) begin
            r_full_ovf <= 1'b1;
          end else begin
            r_wr_ptr <= w_ptr_next;
            if (WRAP == 0 && w_ptr_next == DEPTH) r_full <= 1'b1;
          end
          // Going straight to the read keeps a waiting read one write slot late.
          r_state <= r_rd_busy ? RD_ISSUE : IDLE;
        end
        RD_ISSUE: r_state <= RD_WAIT;
        RD_WAIT: begin
          r_rd_data <= ram_q;
          r_state   <= RD_DONE;
        end
        RD_DONE: begin
          r_rd_busy <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (clr) begin
        r_wr_ptr   <= '0;
        r_full     <= 1'b0;
        r_full_ovf <= 1'b0;
      end
    end
  end

  assign ram_we   = (r_state == WRITE) && !r_full;
  assign ram_addr = (r_state == RD_ISSUE) ? r_rd_hold : r_wr_ptr[ADDR_W-1:0];
  assign ram_din  = w_hold;

  assign rd_if.rd_busy = r_rd_busy;
  assign rd_if.rd_ack  = (r_state == RD_DONE);
  assign rd_if.rd_data = r_rd_data;

  assign wr_ptr   = r_wr_ptr;
  assign full     = r_full;
  assign overflow = r_full_ovf | w_cap_ovf;

endmodule
